// File: rtl/axis_interruptor.sv
// axis_interruptor: AXI-Stream pass-through stage with a 2-entry skid buffer
// that injects pseudo-random output stalls (at most MAX_INTERRUPTIONS per
// packet) so the downstream block sees tvalid gaps. Fully deterministic from
// RAND_SEED.
module axis_interruptor #(
  parameter int          DATA_WIDTH        = 32,
  parameter int          MAX_INTERRUPTIONS = 2,
  parameter int          STALL_THRESHOLD   = 64,
  parameter int          STALL_LEN_LOG2    = 2,
  parameter logic [31:0] RAND_SEED         = 32'd2727272
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  stalled,
  output logic [15:0]           intr_count
);

  typedef enum logic {PASS, STALL} state_t;

  // intr_left must hold 0..MAX_INTERRUPTIONS; keep at least one bit.
  localparam int             IW       = (MAX_INTERRUPTIONS < 2) ? 1 : $clog2(MAX_INTERRUPTIONS + 1);
  localparam logic [IW-1:0]  INTR_MAX = IW'(MAX_INTERRUPTIONS);
  localparam logic [31:0]    TAPS     = 32'h80200003;
  localparam logic [8:0]     THRESH   = 9'(STALL_THRESHOLD);
  // Mask form of lfsr[8 +: STALL_LEN_LOG2] that stays legal when the width is 0.
  localparam logic [4:0]     LEN_MASK = 5'((1 << STALL_LEN_LOG2) - 1);

  logic [DATA_WIDTH:0] mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  state_t              state, state_next;
  logic [4:0]          stall_cnt, stall_cnt_next;
  logic [IW-1:0]       intr_left, intr_left_next;
  logic [31:0]         lfsr;
  logic [4:0]          stall_len;
  logic                push;
  logic                pop;
  logic                start_stall;

  assign s_axis_tready = (count != 2'd2);
  assign m_axis_tvalid = (count != 2'd0) && (state == PASS);
  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];
  assign stalled       = (state == STALL);

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Decision uses the pre-shift LFSR value of the pop cycle; never on a tlast beat.
  assign start_stall = pop && !m_axis_tlast && enable && (intr_left != '0)
                       && ({1'b0, lfsr[7:0]} < THRESH);
  assign stall_len   = (lfsr[12:8] & LEN_MASK) + 5'd1;

  // Skid buffer storage, pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entries are reset so the head reads as zero data/last after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Free-running Galois LFSR, shifts every non-reset cycle regardless of traffic.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= RAND_SEED;
    else     lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  end

  // Next-state logic for the PASS/STALL machine and the per-packet stall budget.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_next     = state;
    stall_cnt_next = stall_cnt;
    intr_left_next = intr_left;
    case (state)
      PASS: begin
        if (start_stall) begin
          state_next     = STALL;
          stall_cnt_next = stall_len;
        end
      end
      STALL: begin
        // Countdown ignores m_axis_tready; the stall lasts exactly stall_len cycles.
        stall_cnt_next = stall_cnt - 5'd1;
        if (stall_cnt == 5'd1) state_next = PASS;
      end
      default: state_next = PASS;
    endcase
    if (pop && m_axis_tlast) intr_left_next = INTR_MAX;
    else if (start_stall)    intr_left_next = intr_left - IW'(1);
  end

  // State register, stall countdown, stall budget and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PASS;
      stall_cnt  <= 5'd0;
      intr_left  <= INTR_MAX;
      intr_count <= 16'd0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      intr_left <= intr_left_next;
      if (start_stall && (intr_count != 16'hFFFF)) intr_count <= intr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_interruptor.sv
// Self-checking bench for axis_interruptor: three parameterisations driven by
// the same random stimulus, each compared every cycle against a queue-level
// reference model built from the stall rules.
module tb_axis_interruptor;

  localparam logic [31:0] SEED   = 32'd2727272;
  localparam int          NSTIM  = 1000;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic        rst;
    logic        enable;
    logic        s_valid;
    logic        s_last;
    logic [31:0] s_data;
    logic        m_ready;
  } stim_t;

  typedef struct {
    beat_t       q0;
    beat_t       q1;
    int          n;
    int          stall_left;
    int          intr_left;
    int          intr_count;
    logic [31:0] lfsr;
  } model_t;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_last, m_ready;
  logic [31:0] s_data;

  logic [31:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid, a_last, b_last, c_last;
  logic        a_ready, b_ready, c_ready, a_stall, b_stall, c_stall;
  logic [15:0] a_ic, b_ic, c_ic;

  int n_vec  = 0;
  int n_miss = 0;

  stim_t  stim [NSTIM];
  model_t ma, mb, mc;

  always #5 clk = ~clk;

  // Default configuration.
  axis_interruptor #(.DATA_WIDTH(32), .MAX_INTERRUPTIONS(2), .STALL_THRESHOLD(64),
                     .STALL_LEN_LOG2(2), .RAND_SEED(SEED)) u_a (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(a_ready),
    .m_axis_tdata(a_data), .m_axis_tvalid(a_valid), .m_axis_tlast(a_last), .m_axis_tready(m_ready),
    .stalled(a_stall), .intr_count(a_ic));

  // Forced stalls: always stall when eligible, fixed one-cycle length.
  axis_interruptor #(.DATA_WIDTH(32), .MAX_INTERRUPTIONS(2), .STALL_THRESHOLD(256),
                     .STALL_LEN_LOG2(0), .RAND_SEED(SEED)) u_b (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(b_ready),
    .m_axis_tdata(b_data), .m_axis_tvalid(b_valid), .m_axis_tlast(b_last), .m_axis_tready(m_ready),
    .stalled(b_stall), .intr_count(b_ic));

  // Passthrough: threshold 0 never stalls.
  axis_interruptor #(.DATA_WIDTH(32), .MAX_INTERRUPTIONS(2), .STALL_THRESHOLD(0),
                     .STALL_LEN_LOG2(2), .RAND_SEED(SEED)) u_c (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(c_ready),
    .m_axis_tdata(c_data), .m_axis_tvalid(c_valid), .m_axis_tlast(c_last), .m_axis_tready(m_ready),
    .stalled(c_stall), .intr_count(c_ic));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset(input int mx, input logic [31:0] seed);
    model_t m;
    m.q0 = '0;  m.q1 = '0;  m.n = 0;  m.stall_left = 0;
    m.intr_left = mx;  m.intr_count = 0;  m.lfsr = seed;
    return m;
  endfunction

  // One clock edge of the reference: queue of beats plus stall rules.
  function automatic model_t model_step(input model_t m, input stim_t s, input int th,
                                        input int ll, input int mx, input logic [31:0] seed);
    model_t nx;
    bit valid, pop, push;
    if (s.rst) return model_reset(mx, seed);
    nx    = m;
    valid = (m.n > 0) && (m.stall_left == 0);
    pop   = valid && s.m_ready;
    push  = s.s_valid && (m.n != 2);
    if (m.stall_left > 0) begin
      nx.stall_left = m.stall_left - 1;
    end else if (pop) begin
      if (m.q0.last) begin
        nx.intr_left = mx;
      end else if (s.enable && m.intr_left > 0 && int'(m.lfsr[7:0]) < th) begin
        nx.stall_left = int'((m.lfsr >> 8) & ((32'd1 << ll) - 1)) + 1;
        nx.intr_left  = m.intr_left - 1;
        if (m.intr_count < 65535) nx.intr_count = m.intr_count + 1;
      end
    end
    if (pop) begin
      nx.q0 = nx.q1;
      nx.n  = nx.n - 1;
    end
    if (push) begin
      if (nx.n == 0) nx.q0 = {s.s_last, s.s_data};
      else           nx.q1 = {s.s_last, s.s_data};
      nx.n = nx.n + 1;
    end
    nx.lfsr = m.lfsr[0] ? ((m.lfsr >> 1) ^ 32'h80200003) : (m.lfsr >> 1);
    return nx;
  endfunction

  task automatic check_dut(input string p, input model_t m, input logic tv, input logic tr,
                           input logic st, input logic [15:0] ic, input logic [31:0] d,
                           input logic l);
    logic exp_valid;
    exp_valid = (m.n > 0) && (m.stall_left == 0);
    check({p, "_tvalid"}, 64'(tv), 64'(exp_valid));
    check({p, "_sready"}, 64'(tr), 64'(m.n != 2));
    check({p, "_stalled"}, 64'(st), 64'(m.stall_left > 0));
    check({p, "_intr_count"}, 64'(ic), 64'(m.intr_count));
    if (exp_valid) begin
      check({p, "_tdata"}, 64'(d), 64'(m.q0.data));
      check({p, "_tlast"}, 64'(l), 64'(m.q0.last));
    end
  endtask

  // Compare current outputs, then apply the next inputs and advance the models.
  task automatic cycle(input stim_t s);
    @(negedge clk);
    check_dut("a", ma, a_valid, a_ready, a_stall, a_ic, a_data, a_last);
    check_dut("b", mb, b_valid, b_ready, b_stall, b_ic, b_data, b_last);
    check_dut("c", mc, c_valid, c_ready, c_stall, c_ic, c_data, c_last);
    rst = s.rst;  enable = s.enable;  s_valid = s.s_valid;
    s_last = s.s_last;  s_data = s.s_data;  m_ready = s.m_ready;
    ma = model_step(ma, s, 64,  2, 2, SEED);
    mb = model_step(mb, s, 256, 0, 2, SEED);
    mc = model_step(mc, s, 0,   2, 2, SEED);
  endtask

  task automatic check_reset_state(input string p, input logic tv, input logic tr, input logic st,
                                   input logic [15:0] ic, input logic [31:0] d, input logic l);
    check({p, "_rst_tvalid"}, 64'(tv), 64'd0);
    check({p, "_rst_sready"}, 64'(tr), 64'd1);
    check({p, "_rst_stalled"}, 64'(st), 64'd0);
    check({p, "_rst_intr_count"}, 64'(ic), 64'd0);
    check({p, "_rst_tdata"}, 64'(d), 64'd0);
    check({p, "_rst_tlast"}, 64'(l), 64'd0);
  endtask

  initial begin
    stim_t s;
    bit    found;
    rst = 1'b1;  enable = 1'b1;  s_valid = 1'b0;  s_last = 1'b0;  s_data = '0;  m_ready = 1'b1;
    ma = model_reset(2, SEED);  mb = model_reset(2, SEED);  mc = model_reset(2, SEED);

    // Random stimulus: enable-off window, ready-low bursts, one mid-run reset.
    for (int i = 0; i < NSTIM; i++) begin
      stim[i].rst     = (i == 700) || (i == 701);
      stim[i].enable  = !(i >= 300 && i < 420);
      stim[i].s_valid = ($urandom_range(0, 9) < 8);
      stim[i].s_last  = ($urandom_range(0, 4) == 0);
      stim[i].s_data  = $urandom;
      stim[i].m_ready = ((i % 97) >= 90) ? 1'b0 : ($urandom_range(0, 9) != 0);
    end

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("a", a_valid, a_ready, a_stall, a_ic, a_data, a_last);
    check_reset_state("b", b_valid, b_ready, b_stall, b_ic, b_data, b_last);

    // Directed forced-stall packet 0..7 with ready held high.
    for (int i = 0; i < 8; i++) begin
      s = '{rst: 1'b0, enable: 1'b1, s_valid: 1'b1, s_last: (i == 7), s_data: 32'(i), m_ready: 1'b1};
      cycle(s);
    end
    s = '{rst: 1'b0, enable: 1'b1, s_valid: 1'b0, s_last: 1'b0, s_data: 32'd0, m_ready: 1'b1};
    repeat (12) cycle(s);
    check("b_packet_intr_count", 64'(b_ic), 64'd2);
    check("c_packet_intr_count", 64'(c_ic), 64'd0);

    // Same random sequence applied twice from reset: both runs must follow the model.
    for (int pass = 0; pass < 2; pass++) begin
      s = '{rst: 1'b1, enable: 1'b1, s_valid: 1'b0, s_last: 1'b0, s_data: 32'd0, m_ready: 1'b1};
      cycle(s);
      for (int i = 0; i < NSTIM; i++) cycle(stim[i]);
    end

    // Reset during a stall of the default configuration.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      s = '{rst: 1'b0, enable: 1'b1, s_valid: 1'b1, s_last: ($urandom_range(0, 7) == 0),
            s_data: $urandom, m_ready: 1'b1};
      cycle(s);
      found = a_stall;
    end
    check("a_stall_seen", 64'(found), 64'd1);
    s = '{rst: 1'b1, enable: 1'b1, s_valid: 1'b1, s_last: 1'b0, s_data: 32'hDEAD_BEEF, m_ready: 1'b1};
    cycle(s);
    @(posedge clk);
    #1;
    check_reset_state("a", a_valid, a_ready, a_stall, a_ic, a_data, a_last);
    s = '{rst: 1'b0, enable: 1'b0, s_valid: 1'b0, s_last: 1'b0, s_data: 32'd0, m_ready: 1'b1};
    repeat (4) cycle(s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
